// File: rtl/alu_pkg.sv
// alu_pkg: shared comparator flag encoding, search FSM states and default width
package alu_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam logic [3:0] FLAG_ON = 4'b0001;
    localparam logic [3:0] FLAG_OFF = 4'b0000;
    typedef enum logic [1:0] {IDLE, TEST, FIN} state_t;
endpackage

// File: rtl/cmp_flag_decode.sv
// cmp_flag_decode: turns G/S/Q flag words into one-hot gt/lt/eq plus an invalid flag
module cmp_flag_decode
    import alu_pkg::*;
(
    input  logic [3:0] g,
    input  logic [3:0] s,
    input  logic [3:0] q,
    output logic       gt,
    output logic       lt,
    output logic       eq,
    output logic       invalid
);
    logic legal;
    logic [1:0] count;
    assign legal = (g == FLAG_ON || g == FLAG_OFF) && (s == FLAG_ON || s == FLAG_OFF) && (q == FLAG_ON || q == FLAG_OFF);
    assign count = 2'(g == FLAG_ON) + 2'(s == FLAG_ON) + 2'(q == FLAG_ON);
    assign invalid = !(legal && count == 2'd1);
    assign gt = !invalid && g == FLAG_ON;
    assign lt = !invalid && s == FLAG_ON;
    assign eq = !invalid && q == FLAG_ON;
endmodule

// File: rtl/sar_search_unit.sv
// sar_search_unit: successive-approximation search recovering the comparator A operand
module sar_search_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       CMP_G,
    input  logic [3:0]       CMP_S,
    input  logic [3:0]       CMP_Q,
    output logic [WIDTH-1:0] TRIAL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             EXACT,
    output logic             ERR
);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    state_t state;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] acc, nacc, nxt_bit;
    logic gt, lt, eq, invalid, fin;
    cmp_flag_decode u_dec (
        .g(CMP_G),
        .s(CMP_S),
        .q(CMP_Q),
        .gt(gt),
        .lt(lt),
        .eq(eq),
        .invalid(invalid)
    );
    // TRIAL already holds acc with the current bit set, so a G keeps it and an S falls back to acc
    assign nacc = gt ? TRIAL : (lt ? acc : '0);
    assign nxt_bit = WIDTH'(1) << (idx - IW'(1));
    assign fin = invalid || eq || idx == '0;
    // search FSM with registered outputs; DONE is high for the single FIN cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            TRIAL <= '0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            RESULT <= '0;
            EXACT <= 1'b0;
            ERR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    TRIAL <= '0;
                    BUSY <= 1'b0;
                    if (START) begin
                        state <= TEST;
                        idx <= IW'(WIDTH - 1);
                        acc <= '0;
                        TRIAL <= WIDTH'(1) << (WIDTH - 1);
                        BUSY <= 1'b1;
                        EXACT <= 1'b0;
                        ERR <= 1'b0;
                    end
                end
                TEST: begin
                    if (fin) begin
                        state <= FIN;
                        DONE <= 1'b1;
                        BUSY <= 1'b0;
                        TRIAL <= '0;
                        RESULT <= invalid ? '0 : (eq ? TRIAL : nacc);
                        EXACT <= !invalid && eq;
                        ERR <= invalid;
                    end else begin
                        idx <= idx - IW'(1);
                        acc <= nacc;
                        TRIAL <= nacc | nxt_bit;
                    end
                end
                FIN: begin
                    DONE <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_search_unit.sv
// tb_sar_search_unit: comparator model, vector table and scoreboard for the SAR searcher
module tb_sar_search_unit;
    import alu_pkg::*;
    localparam int W = 4;
    logic CLK = 1'b0;
    logic RST, START;
    logic [3:0] CMP_G, CMP_S, CMP_Q;
    logic [W-1:0] TRIAL, RESULT;
    logic BUSY, DONE, EXACT, ERR;
    logic [W-1:0] a_val;
    logic ov;
    logic [3:0] ov_g, ov_s, ov_q;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    typedef struct {
        logic [W-1:0] res;
        logic exact;
        logic err;
        int lat;
        int c0;
    } exp_t;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] res;
        logic exact;
        int lat;
    } vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t vecs[10];

    sar_search_unit #(.WIDTH(W)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .CMP_G(CMP_G),
        .CMP_S(CMP_S),
        .CMP_Q(CMP_Q),
        .TRIAL(TRIAL),
        .BUSY(BUSY),
        .DONE(DONE),
        .RESULT(RESULT),
        .EXACT(EXACT),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // combinational comparator against a_val, with a manual flag override
    always_comb begin
        CMP_G = ov ? ov_g : (a_val > TRIAL ? FLAG_ON : FLAG_OFF);
        CMP_S = ov ? ov_s : (a_val < TRIAL ? FLAG_ON : FLAG_OFF);
        CMP_Q = ov ? ov_q : (a_val == TRIAL ? FLAG_ON : FLAG_OFF);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // every DONE pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("result", RESULT, e.res);
                check("exact", EXACT, e.exact);
                check("err", ERR, e.err);
                check("latency", cyc - e.c0, e.lat);
            end
        end
    end

    task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] res, input logic exact,
                             input logic err, input int lat, input logic hold);
        @(negedge CLK);
        a_val = a;
        START = 1'b1;
        @(posedge CLK);
        #1;
        sb.push_back('{res, exact, err, lat, cyc});
        @(negedge CLK);
        if (!hold) START = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge CLK);
        check("idle_busy", BUSY, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        START = 1'b0;
        ov = 1'b0;
        ov_g = FLAG_OFF;
        ov_s = FLAG_OFF;
        ov_q = FLAG_OFF;
        a_val = '0;
        vecs[0] = '{4'hB, 4'hB, 1'b1, 4};
        vecs[1] = '{4'h8, 4'h8, 1'b1, 1};
        vecs[2] = '{4'h0, 4'h0, 1'b0, 4};
        vecs[3] = '{4'hF, 4'hF, 1'b1, 4};
        vecs[4] = '{4'h5, 4'h5, 1'b1, 4};
        vecs[5] = '{4'h3, 4'h3, 1'b1, 4};
        vecs[6] = '{4'h6, 4'h6, 1'b1, 3};
        vecs[7] = '{4'h4, 4'h4, 1'b1, 2};
        vecs[8] = '{4'hC, 4'hC, 1'b1, 2};
        vecs[9] = '{4'h1, 4'h1, 1'b1, 4};
        repeat (2) @(negedge CLK);
        check("rst_trial", TRIAL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_result", RESULT, 0);
        check("rst_exact", EXACT, 0);
        check("rst_err", ERR, 0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_req(vecs[i].a, vecs[i].res, vecs[i].exact, 1'b0, vecs[i].lat, 1'b0);
            wait_done();
            repeat (2) @(negedge CLK);
            check("result_hold", RESULT, vecs[i].res);
        end

        start_req(4'hB, 4'hB, 1'b1, 1'b0, 4, 1'b0);
        check("trial1", TRIAL, 4'b1000);
        check("busy1", BUSY, 1);
        @(negedge CLK);
        check("trial2", TRIAL, 4'b1100);
        @(negedge CLK);
        check("trial3", TRIAL, 4'b1010);
        @(negedge CLK);
        check("trial4", TRIAL, 4'b1011);
        wait_done();
        check("idle_trial", TRIAL, 0);

        start_req(4'h5, 4'h0, 1'b0, 1'b1, 2, 1'b0);
        @(negedge CLK);
        ov = 1'b1;
        ov_g = FLAG_ON;
        ov_s = FLAG_ON;
        ov_q = FLAG_OFF;
        @(negedge CLK);
        ov = 1'b0;
        wait_done();
        check("err_hold", ERR, 1);

        start_req(4'h5, 4'h0, 1'b0, 1'b1, 1, 1'b0);
        ov = 1'b1;
        ov_g = FLAG_OFF;
        ov_s = FLAG_OFF;
        ov_q = 4'b0010;
        @(negedge CLK);
        ov = 1'b0;
        wait_done();

        start_req(4'h5, 4'h5, 1'b1, 1'b0, 4, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        check("pre_rst_trial3", TRIAL, 4'b0110);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        sb.delete();
        check("mid_rst_trial", TRIAL, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_done", DONE, 0);
        check("mid_rst_result", RESULT, 0);
        check("mid_rst_exact", EXACT, 0);
        check("mid_rst_err", ERR, 0);
        repeat (8) @(negedge CLK);
        check("post_rst_busy", BUSY, 0);
        start_req(4'h5, 4'h5, 1'b1, 1'b0, 4, 1'b0);
        wait_done();

        start_req(4'hB, 4'hB, 1'b1, 1'b0, 4, 1'b1);
        repeat (3) begin
            @(negedge CLK);
            check("busy_hold", BUSY, 1);
        end
        @(negedge CLK);
        check("fin_done", DONE, 1);
        @(negedge CLK);
        check("b2b_idle_busy", BUSY, 0);
        check("b2b_idle_done", DONE, 0);
        a_val = 4'h8;
        @(posedge CLK);
        #1;
        sb.push_back('{4'h8, 1'b1, 1'b0, 1, cyc});
        @(negedge CLK);
        START = 1'b0;
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
